// File: rtl/filter_sched_pkg.sv
// Shared definitions for the biquad channel scheduler: FSM encoding, slot length
// default and a one-hot to index helper.
package filter_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ARB  = ST_ARB,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  localparam int SLOT_CYCLES_DEFAULT = 7;

  // OR-reduces the positions of set bits; exact for a one-hot or all-zero input.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = onehot[i] ? (idx | 4'(i)) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/filter_channel_scheduler_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping at N_CH-1.
module filter_rr_arbiter
  import filter_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  localparam int SW = CH_W + 1;

  logic [SW-1:0] cand_s;

  // Scan channels ptr+1 .. ptr+N_CH (mod N_CH) and take the first request
  always_comb begin
    gnt    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = 1; i <= N_CH; i++) begin
      cand_s = {1'b0, ptr} + SW'(i);
      cand_s = (cand_s >= SW'(N_CH)) ? (cand_s - SW'(N_CH)) : cand_s;
      if (!any && req[cand_s[CH_W-1:0]]) begin
        any                     = 1'b1;
        gnt[cand_s[CH_W-1:0]]   = 1'b1;
      end else begin
        any = any;
      end
    end
    idx = CH_W'(onehot_to_idx(16'(gnt)));
  end

endmodule

// File: rtl/filter_channel_scheduler.sv
// Time-multiplexes one 7-step biquad engine over N_CH channels, one slot per sample.
// Optional FILTER_SCHED_PRIORITY_EN: channel 0 pre-empts the round-robin rotation.
module filter_channel_scheduler
  import filter_sched_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int SLOT_CYCLES = SLOT_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [N_CH-1:0] sample_valid,
  input  logic            overrun_clr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] ch_sel,
  output logic            engine_reset,
  output logic            engine_enable,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic            busy,
  output logic [N_CH-1:0] overrun
);

  localparam int              SW        = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOT_CYCLES - 1);
  localparam logic [N_CH-1:0] CH0_MASK  = {{(N_CH-1){1'b0}}, 1'b1};

  state_t          state_r, state_s;
  logic [SW-1:0]   slot_cnt_r, slot_cnt_s;
  logic [N_CH-1:0] pending_r, pending_s;
  logic [N_CH-1:0] overrun_r, overrun_s;
  logic [N_CH-1:0] grant_r, grant_s;
  logic [CH_W-1:0] last_ch_r, last_ch_s;
  logic [CH_W-1:0] ch_sel_r, ch_sel_s;
  logic [CH_W-1:0] out_ch_r, out_ch_s;
  logic            engine_reset_r, engine_reset_s;
  logic            engine_enable_r, engine_enable_s;
  logic            out_valid_r, out_valid_s;
  logic            busy_r, busy_s;

  logic [N_CH-1:0] arb_req_s, arb_gnt_s, pick_gnt_s;
  logic [CH_W-1:0] arb_idx_s, pick_idx_s;
  logic            arb_any_s, pick_any_s, pick_upd_s;

`ifdef FILTER_SCHED_PRIORITY_EN
  assign arb_req_s = pending_r & ~CH0_MASK;
`else
  assign arb_req_s = pending_r;
`endif

  filter_rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req (arb_req_s),
    .ptr (last_ch_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s),
    .any (arb_any_s)
  );

  // Final channel pick; a priority grant of channel 0 leaves the rotation pointer alone
  always_comb begin
`ifdef FILTER_SCHED_PRIORITY_EN
    if (pending_r[0]) begin
      pick_gnt_s = CH0_MASK;
      pick_idx_s = '0;
      pick_any_s = 1'b1;
      pick_upd_s = 1'b0;
    end else begin
      pick_gnt_s = arb_gnt_s;
      pick_idx_s = arb_idx_s;
      pick_any_s = arb_any_s;
      pick_upd_s = 1'b1;
    end
`else
    pick_gnt_s = arb_gnt_s;
    pick_idx_s = arb_idx_s;
    pick_any_s = arb_any_s;
    pick_upd_s = 1'b1;
`endif
  end

  // Sample latching; a strobe on a bit being granted re-arms it without an overrun
  always_comb begin
    pending_s = (pending_r & ~grant_r) | sample_valid;
    overrun_s = (overrun_clr ? '0 : overrun_r) | (sample_valid & pending_r & ~grant_r);
  end

  // Progress only when the current state's action was actually issued (enable may veto it)
  always_comb begin
    state_s    = state_r;
    slot_cnt_s = slot_cnt_r;
    case (state_r)
      IDLE: state_s = (enable && (|pending_r)) ? ARB : IDLE;
      ARB: begin
        state_s    = (|grant_r) ? RUN : ARB;
        slot_cnt_s = (|grant_r) ? '0 : slot_cnt_r;
      end
      RUN: begin
        if (engine_enable_r && (slot_cnt_r == SLOT_LAST)) begin
          state_s = DONE;
        end else if (engine_enable_r) begin
          slot_cnt_s = slot_cnt_r + SW'(1);
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_valid_r) begin
          state_s = (|pending_r) ? ARB : IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    grant_s         = '0;
    engine_reset_s  = 1'b0;
    engine_enable_s = 1'b0;
    out_valid_s     = 1'b0;
    ch_sel_s        = ch_sel_r;
    last_ch_s       = last_ch_r;
    out_ch_s        = out_ch_r;
    busy_s          = (state_s != IDLE);
    case (state_s)
      ARB: begin
        if (enable && pick_any_s) begin
          grant_s        = pick_gnt_s;
          engine_reset_s = 1'b1;
          ch_sel_s       = pick_idx_s;
          last_ch_s      = pick_upd_s ? pick_idx_s : last_ch_r;
        end else begin
          grant_s = '0;
        end
      end
      RUN:  engine_enable_s = enable;
      DONE: begin
        out_valid_s = enable;
        out_ch_s    = enable ? ch_sel_r : out_ch_r;
      end
      default: grant_s = '0;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      slot_cnt_r      <= '0;
      pending_r       <= '0;
      overrun_r       <= '0;
      grant_r         <= '0;
      last_ch_r       <= CH_W'(N_CH - 1);
      ch_sel_r        <= '0;
      out_ch_r        <= '0;
      engine_reset_r  <= 1'b0;
      engine_enable_r <= 1'b0;
      out_valid_r     <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      slot_cnt_r      <= slot_cnt_s;
      pending_r       <= pending_s;
      overrun_r       <= overrun_s;
      grant_r         <= grant_s;
      last_ch_r       <= last_ch_s;
      ch_sel_r        <= ch_sel_s;
      out_ch_r        <= out_ch_s;
      engine_reset_r  <= engine_reset_s;
      engine_enable_r <= engine_enable_s;
      out_valid_r     <= out_valid_s;
      busy_r          <= busy_s;
    end
  end

  assign grant         = grant_r;
  assign ch_sel        = ch_sel_r;
  assign engine_reset  = engine_reset_r;
  assign engine_enable = engine_enable_r;
  assign out_valid     = out_valid_r;
  assign out_ch        = out_ch_r;
  assign busy          = busy_r;
  assign overrun       = overrun_r;

endmodule
